// File: rtl/find_star_pixel.sv
// find_star_pixel: raster-scans a 160x120 pixel memory and reports the first star pixel.
//   clk         single clock
//   resetn      asynchronous active-low reset
//   go          level request; high starts a scan, low returns to idle
//   addressRead pixel memory read address (0 outside SCAN)
//   pixVal      pixel memory read data, valid one clk after addressRead
//   xIn, yIn    coordinate of the found pixel (held until the next hit)
//   starFound   high while a hit is held
//   noStar      high while a completed scan without a hit is held
// Optional build macro STAR_COLOUR_MATCH_EN: hit means pixVal == STAR_COLOUR;
// otherwise any non-black pixel is a hit.
module find_star_pixel #(
  parameter int xSz = 8,
  parameter int ySz = 7,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119,
  parameter logic [3:0] STAR_COLOUR = 4'h7
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            go,
  output logic [14:0]     addressRead,
  input  logic [3:0]      pixVal,
  output logic [xSz-1:0]  xIn,
  output logic [ySz-1:0]  yIn,
  output logic            starFound,
  output logic            noStar
);
  typedef enum logic [1:0] {IDLE, SCAN, FOUND, EMPTY} stateT;
  localparam logic [xSz-1:0] xLast = xSz'(X_MAX);
  localparam logic [ySz-1:0] yLast = ySz'(Y_MAX);
  stateT state;
  logic [xSz-1:0] x, xd;
  logic [ySz-1:0] y, yd;
  logic vd, hit, atEnd;
  logic [14:0] xw, yw;
`ifdef STAR_COLOUR_MATCH_EN
  assign hit = pixVal == STAR_COLOUR;
`else
  assign hit = pixVal != 4'h0;
`endif
  assign xw = 15'(x);
  assign yw = 15'(y);
  // y*160 as two shifts; address only presented while scanning
  assign addressRead = (state == SCAN) ? (yw << 7) + (yw << 5) + xw : '0;
  assign atEnd = (x == xLast) && (y == yLast);
  // (xd, yd, vd) tracks the address issued last cycle, which pixVal now answers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      xd <= '0;
      yd <= '0;
      vd <= 1'b0;
      xIn <= '0;
      yIn <= '0;
      starFound <= 1'b0;
      noStar <= 1'b0;
    end else if (!go) begin
      state <= IDLE;
      vd <= 1'b0;
      starFound <= 1'b0;
      noStar <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= SCAN;
          x <= '0;
          y <= '0;
          vd <= 1'b0;
        end
        SCAN: begin
          if (vd && hit) begin
            state <= FOUND;
            xIn <= xd;
            yIn <= yd;
            starFound <= 1'b1;
          end else if (vd && xd == xLast && yd == yLast) begin
            state <= EMPTY;
            noStar <= 1'b1;
          end else begin
            xd <= x;
            yd <= y;
            vd <= 1'b1;
            // counter parks on the last pixel instead of wrapping to (0,0)
            if (!atEnd) begin
              x <= (x == xLast) ? '0 : x + 1'b1;
              if (x == xLast) y <= y + 1'b1;
            end
          end
        end
        FOUND, EMPTY: ;
      endcase
    end
  end
endmodule
